// File: rtl/ft_frame_loopback_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ft_frame_loopback_if                                           |
// | Purpose  : FT2232 IN-FIFO read port and OUT-FIFO write port bundle        |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface ft_frame_loopback_if;
  logic       rd_in_fifo_clk_o;
  logic       rd_in_fifo_en_o;
  logic [7:0] rd_in_fifo_data_i;
  logic       rd_in_fifo_empty_i;
  logic       wr_out_fifo_clk_o;
  logic       wr_out_fifo_en_o;
  logic [7:0] wr_out_fifo_data_o;
  logic       wr_out_fifo_full_i;
  logic       wr_out_fifo_afull_i;

  modport master (
    output rd_in_fifo_clk_o, rd_in_fifo_en_o,
    input  rd_in_fifo_data_i, rd_in_fifo_empty_i,
    output wr_out_fifo_clk_o, wr_out_fifo_en_o, wr_out_fifo_data_o,
    input  wr_out_fifo_full_i, wr_out_fifo_afull_i
  );

  modport slave (
    input  rd_in_fifo_clk_o, rd_in_fifo_en_o,
    output rd_in_fifo_data_i, rd_in_fifo_empty_i,
    input  wr_out_fifo_clk_o, wr_out_fifo_en_o, wr_out_fifo_data_o,
    output wr_out_fifo_full_i, wr_out_fifo_afull_i
  );
endinterface
`default_nettype wire

// File: rtl/ft_frame_loopback.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ft_frame_loopback                                              |
// | Purpose  : parses host frames from the IN FIFO and echoes them with a     |
// |            status byte into the OUT FIFO                                  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ft_frame_loopback #(
  parameter logic [7:0] SOF            = 8'hA5,
  parameter logic [7:0] RSP            = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  wire                 fifo_clk_i,
  input  wire                 reset_i,
  ft_frame_loopback_if.master fifo,
  output logic                busy_o,
  output logic [15:0]         frame_ok_count_o,
  output logic [15:0]         frame_err_count_o
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] c_IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] c_HUNT    = 3'd0;
  localparam logic [2:0] c_LEN     = 3'd1;
  localparam logic [2:0] c_PAYLOAD = 3'd2;
  localparam logic [2:0] c_CSUM    = 3'd3;
  localparam logic [2:0] c_STATUS  = 3'd4;

  localparam logic [7:0] c_ST_OK      = 8'h00;
  localparam logic [7:0] c_ST_CSUM    = 8'h01;
  localparam logic [7:0] c_ST_TIMEOUT = 8'h02;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic              r_rd_pend;
  logic [IDLE_W-1:0] r_idle;
  logic [7:0]        r_sum;
  logic [7:0]        r_rem;
  logic [7:0]        r_status;
  logic              r_wr_en;
  logic [7:0]        r_wr_data;
  logic [15:0]       r_ok_cnt;
  logic [15:0]       r_err_cnt;

  logic              w_space;
  logic              w_rd_en;
  logic              w_consume;
  logic [7:0]        w_byte;
  logic [7:0]        w_csum_total;
  logic              w_timed;
  logic              w_timeout;

  assign w_space      = !fifo.wr_out_fifo_full_i && !fifo.wr_out_fifo_afull_i;
  assign w_consume    = r_rd_pend;
  assign w_byte       = fifo.rd_in_fifo_data_i;
  assign w_csum_total = r_sum + w_byte;
  assign w_timed      = (r_state == c_LEN) || (r_state == c_PAYLOAD) || (r_state == c_CSUM);
  // A read issued this cycle wins over an expiring idle counter.
  assign w_timeout    = w_timed && (r_idle == c_IDLE_MAX) && !r_rd_pend && !w_rd_en;

  always_ff @(posedge fifo_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= c_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_HUNT: begin
        if (w_consume && (w_byte == SOF)) w_state_next = c_LEN;
      end
      c_LEN: begin
        if (w_consume)      w_state_next = (w_byte == 8'h00) ? c_CSUM : c_PAYLOAD;
        else if (w_timeout) w_state_next = c_STATUS;
      end
      c_PAYLOAD: begin
        if (w_consume) begin
          if (r_rem == 8'd1) w_state_next = c_CSUM;
        end else if (w_timeout) begin
          w_state_next = c_STATUS;
        end
      end
      c_CSUM: begin
        if (w_consume || w_timeout) w_state_next = c_STATUS;
      end
      c_STATUS: begin
        if (w_space) w_state_next = c_HUNT;
      end
      default: w_state_next = c_HUNT;
    endcase
  end

  // Strobe is combinational so it can honour empty/full sampled in the same cycle.
  always_comb begin
    w_rd_en = 1'b0;
    if (!reset_i && (r_state != c_STATUS) && !r_rd_pend &&
        !fifo.rd_in_fifo_empty_i && w_space) begin
      w_rd_en = 1'b1;
    end
    busy_o = (r_state != c_HUNT);
  end

  always_ff @(posedge fifo_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd_pend <= 1'b0;
      r_idle    <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (!w_timed || w_consume || (w_state_next != r_state)) begin
        r_idle <= '0;
      end else if (r_idle != c_IDLE_MAX) begin
        r_idle <= r_idle + IDLE_W'(1);
      end
    end
  end

  always_ff @(posedge fifo_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sum     <= 8'h00;
      r_rem     <= 8'h00;
      r_status  <= c_ST_OK;
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'h00;
      r_ok_cnt  <= 16'h0000;
      r_err_cnt <= 16'h0000;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        c_HUNT: begin
          if (w_consume && (w_byte == SOF)) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= RSP;
          end
        end
        c_LEN: begin
          if (w_consume) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_byte;
            r_rem     <= w_byte;
            r_sum     <= w_byte;
          end else if (w_timeout) begin
            r_status <= c_ST_TIMEOUT;
          end
        end
        c_PAYLOAD: begin
          if (w_consume) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_byte;
            r_sum     <= w_csum_total;
            r_rem     <= r_rem - 8'd1;
          end else if (w_timeout) begin
            r_status <= c_ST_TIMEOUT;
          end
        end
        c_CSUM: begin
          if (w_consume) begin
            r_status <= (w_csum_total == 8'h00) ? c_ST_OK : c_ST_CSUM;
          end else if (w_timeout) begin
            r_status <= c_ST_TIMEOUT;
          end
        end
        c_STATUS: begin
          if (w_space) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= r_status;
            if (r_status == c_ST_OK) r_ok_cnt  <= r_ok_cnt + 16'd1;
            else                     r_err_cnt <= r_err_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo.rd_in_fifo_clk_o  = fifo_clk_i;
  assign fifo.wr_out_fifo_clk_o = fifo_clk_i;
  assign fifo.rd_in_fifo_en_o   = w_rd_en;
  assign fifo.wr_out_fifo_en_o  = r_wr_en;
  assign fifo.wr_out_fifo_data_o = r_wr_data;
  assign frame_ok_count_o       = r_ok_cnt;
  assign frame_err_count_o      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ft_frame_loopback.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ft_frame_loopback                                           |
// | Purpose  : randomized and directed bench with a frame-level reference     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_ft_frame_loopback;
  localparam int TIMEOUT = 1024;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  bq_t in_q;
  bq_t out_q;
  int  viol_empty = 0;
  int  viol_bp    = 0;
  int  n_cmp      = 0;
  int  n_bad      = 0;
  int  exp_ok     = 0;
  int  exp_err    = 0;

  ft_frame_loopback_if fifo_if ();

  ft_frame_loopback #(
    .SOF            (8'hA5),
    .RSP            (8'h5A),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .fifo_clk_i        (clk),
    .reset_i           (rst),
    .fifo              (fifo_if),
    .busy_o            (busy),
    .frame_ok_count_o  (ok_cnt),
    .frame_err_count_o (err_cnt)
  );

  always #5 clk = ~clk;

  // FIFO models: IN data appears the cycle after an accepted strobe; OUT captures every write.
  always @(posedge clk) begin
    if (fifo_if.rd_in_fifo_en_o) begin
      if (fifo_if.rd_in_fifo_empty_i) viol_empty <= viol_empty + 1;
      if (fifo_if.wr_out_fifo_afull_i || fifo_if.wr_out_fifo_full_i) viol_bp <= viol_bp + 1;
      if (in_q.size() > 0) fifo_if.rd_in_fifo_data_i <= in_q.pop_front();
    end
    fifo_if.rd_in_fifo_empty_i <= (in_q.size() == 0);
    if (fifo_if.wr_out_fifo_en_o) out_q.push_back(fifo_if.wr_out_fifo_data_o);
  end

  // Expected response stream for a sequence of complete host frames plus garbage.
  function automatic void ref_resp(input bq_t s, output bq_t r, output int n_ok, output int n_err);
    int i;
    int len;
    int total;
    r = {};
    n_ok = 0;
    n_err = 0;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      len = int'(s[i+1]);
      r.push_back(8'h5A);
      r.push_back(s[i+1]);
      total = len;
      for (int k = 0; k < len; k++) begin
        r.push_back(s[i+2+k]);
        total += int'(s[i+2+k]);
      end
      total += int'(s[i+2+len]);
      if (total % 256 == 0) begin r.push_back(8'h00); n_ok++; end
      else begin r.push_back(8'h01); n_err++; end
      i += len + 3;
    end
  endfunction

  function automatic bq_t make_frame(input int len, input bit good);
    bq_t f;
    int total;
    logic [7:0] b;
    f = {};
    f.push_back(8'hA5);
    f.push_back(8'(len));
    total = len;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      f.push_back(b);
      total += int'(b);
    end
    b = 8'((256 - total % 256) % 256);
    if (!good) b = b + 8'($urandom_range(1, 255));
    f.push_back(b);
    return f;
  endfunction

  function automatic logic [7:0] rand_garbage();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'hA5);
    return b;
  endfunction

  function automatic int first_diff(input bq_t got, input bq_t exp);
    int n;
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int k = 0; k < n; k++) if (got[k] !== exp[k]) return k;
    if (got.size() != exp.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] byte_at(input bq_t q, input int idx);
    if (idx < q.size()) return q[idx];
    return 8'hxx;
  endfunction

  task automatic push_stream(input bq_t s);
    foreach (s[k]) in_q.push_back(s[k]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int quiet;
    int t;
    quiet = 0;
    t = 0;
    while (quiet < 8 && t < budget) begin
      @(negedge clk);
      t++;
      if (in_q.size() == 0 && !busy && !fifo_if.wr_out_fifo_en_o) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 8) begin
      n_bad++;
      $display("FAIL %s.drain: still active after %0d cycles (in_q=%0d busy=%b), required idle", tag, budget, in_q.size(), busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fifo_if.wr_out_fifo_full_i  = 1'b0;
    fifo_if.wr_out_fifo_afull_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (fifo_if.rd_in_fifo_en_o !== 1'b0) begin n_bad++; $display("FAIL reset.rd_en: got %b required 0", fifo_if.rd_in_fifo_en_o); end
    n_cmp++; if (fifo_if.wr_out_fifo_en_o !== 1'b0) begin n_bad++; $display("FAIL reset.wr_en: got %b required 0", fifo_if.wr_out_fifo_en_o); end
    n_cmp++; if (fifo_if.wr_out_fifo_data_o !== 8'h00) begin n_bad++; $display("FAIL reset.wr_data: got %h required 00", fifo_if.wr_out_fifo_data_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset.busy: got %b required 0", busy); end
    n_cmp++; if (ok_cnt !== 16'h0) begin n_bad++; $display("FAIL reset.ok_cnt: got %h required 0000", ok_cnt); end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset.err_cnt: got %h required 0000", err_cnt); end
    n_cmp++; if (fifo_if.rd_in_fifo_clk_o !== clk || fifo_if.wr_out_fifo_clk_o !== clk) begin
      n_bad++; $display("FAIL reset.clk_pass: got %b/%b required %b", fifo_if.rd_in_fifo_clk_o, fifo_if.wr_out_fifo_clk_o, clk);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed(input string tag, input bq_t stim, input bq_t exp, input int d_ok, input int d_err);
    int d;
    out_q.delete();
    push_stream(stim);
    wait_done(tag, 500);
    exp_ok += d_ok;
    exp_err += d_err;
    d = first_diff(out_q, exp);
    n_cmp++;
    if (d >= 0) begin
      n_bad++;
      $display("FAIL %s.resp: byte %0d got %h required %h (%0d vs %0d bytes)", tag, d, byte_at(out_q, d), byte_at(exp, d), out_q.size(), exp.size());
    end
    n_cmp++; if (ok_cnt !== 16'(exp_ok)) begin n_bad++; $display("FAIL %s.ok_cnt: got %0d required %0d", tag, ok_cnt, exp_ok); end
    n_cmp++; if (err_cnt !== 16'(exp_err)) begin n_bad++; $display("FAIL %s.err_cnt: got %0d required %0d", tag, err_cnt, exp_err); end
  endtask

  task automatic test_good_frame;
    test_directed("good_frame", {8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D},
                  {8'h5A, 8'h03, 8'h10, 8'h20, 8'h30, 8'h00}, 1, 0);
  endtask

  task automatic test_zero_len;
    test_directed("zero_len", {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00}, {8'h5A, 8'h00, 8'h00}, 1, 0);
  endtask

  task automatic test_bad_csum;
    test_directed("bad_csum", {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00},
                  {8'h5A, 8'h02, 8'h01, 8'h02, 8'h01}, 0, 1);
  endtask

  task automatic test_back_to_back_random;
    bq_t s;
    bq_t fr;
    bq_t exp;
    int n_ok;
    int n_err;
    int d;
    for (int it = 0; it < 8; it++) begin
      s = {};
      repeat ($urandom_range(0, 3)) s.push_back(rand_garbage());
      fr = make_frame($urandom_range(0, 40), $urandom_range(0, 2) != 0);
      s = {s, fr};
      if (it % 2 == 1) begin
        fr = make_frame($urandom_range(0, 20), $urandom_range(0, 1) != 0);
        s = {s, fr};
      end
      ref_resp(s, exp, n_ok, n_err);
      out_q.delete();
      push_stream(s);
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        fifo_if.wr_out_fifo_afull_i = ($urandom_range(0, 3) == 0);
        fifo_if.wr_out_fifo_full_i  = ($urandom_range(0, 7) == 0);
      end
      fifo_if.wr_out_fifo_afull_i = 1'b0;
      fifo_if.wr_out_fifo_full_i  = 1'b0;
      wait_done("random", 2000);
      exp_ok += n_ok;
      exp_err += n_err;
      d = first_diff(out_q, exp);
      n_cmp++;
      if (d >= 0) begin
        n_bad++;
        $display("FAIL random[%0d].resp: byte %0d got %h required %h (%0d vs %0d bytes)", it, d, byte_at(out_q, d), byte_at(exp, d), out_q.size(), exp.size());
      end
      n_cmp++;
      if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
        n_bad++;
        $display("FAIL random[%0d].counts: got %0d/%0d required %0d/%0d", it, ok_cnt, err_cnt, exp_ok, exp_err);
      end
    end
    n_cmp++; if (viol_empty !== 0) begin n_bad++; $display("FAIL random.rd_while_empty: got %0d strobes required 0", viol_empty); end
    n_cmp++; if (viol_bp !== 0) begin n_bad++; $display("FAIL random.rd_while_full: got %0d strobes required 0", viol_bp); end
  endtask

  task automatic test_timeout;
    int t;
    int d;
    bq_t exp;
    out_q.delete();
    push_stream({8'hA5, 8'h04, 8'hAA});
    t = 0;
    while (out_q.size() < 3 && t < 100) begin @(negedge clk); t++; end
    repeat (900) @(negedge clk);
    n_cmp++; if (out_q.size() !== 3) begin n_bad++; $display("FAIL timeout.early: got %0d bytes required 3", out_q.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timeout.busy_mid: got %b required 1", busy); end
    wait_done("timeout", 1000);
    exp_err++;
    exp = {8'h5A, 8'h04, 8'hAA, 8'h02};
    d = first_diff(out_q, exp);
    n_cmp++;
    if (d >= 0) begin
      n_bad++;
      $display("FAIL timeout.resp: byte %0d got %h required %h (%0d vs %0d bytes)", d, byte_at(out_q, d), byte_at(exp, d), out_q.size(), exp.size());
    end
    n_cmp++; if (err_cnt !== 16'(exp_err)) begin n_bad++; $display("FAIL timeout.err_cnt: got %0d required %0d", err_cnt, exp_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout.busy_end: got %b required 0", busy); end
    test_directed("after_timeout", {8'hA5, 8'h01, 8'h07, 8'hF8}, {8'h5A, 8'h01, 8'h07, 8'h00}, 1, 0);
  endtask

  task automatic test_backpressure;
    bq_t fr;
    bq_t exp;
    int n_ok;
    int n_err;
    int t;
    int d;
    int v0;
    int sz0;
    fr = make_frame(255, 1'b1);
    ref_resp(fr, exp, n_ok, n_err);
    out_q.delete();
    push_stream(fr);
    t = 0;
    while (out_q.size() < 100 && t < 1000) begin @(negedge clk); t++; end
    fifo_if.wr_out_fifo_afull_i = 1'b1;
    v0 = viol_bp;
    sz0 = out_q.size();
    repeat (50) @(negedge clk);
    n_cmp++; if (viol_bp !== v0) begin n_bad++; $display("FAIL backpressure.rd_strobe: got %0d strobes required 0", viol_bp - v0); end
    n_cmp++; if (out_q.size() - sz0 > 1) begin n_bad++; $display("FAIL backpressure.writes: got %0d writes required at most 1", out_q.size() - sz0); end
    fifo_if.wr_out_fifo_afull_i = 1'b0;
    wait_done("backpressure", 2000);
    exp_ok += n_ok;
    exp_err += n_err;
    d = first_diff(out_q, exp);
    n_cmp++;
    if (d >= 0) begin
      n_bad++;
      $display("FAIL backpressure.resp: byte %0d got %h required %h (%0d vs %0d bytes)", d, byte_at(out_q, d), byte_at(exp, d), out_q.size(), exp.size());
    end
    n_cmp++;
    if (ok_cnt !== 16'(exp_ok) || err_cnt !== 16'(exp_err)) begin
      n_bad++;
      $display("FAIL backpressure.counts: got %0d/%0d required %0d/%0d", ok_cnt, err_cnt, exp_ok, exp_err);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    out_q.delete();
    push_stream(make_frame(255, 1'b1));
    t = 0;
    while (out_q.size() < 20 && t < 500) begin @(negedge clk); t++; end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (fifo_if.rd_in_fifo_en_o !== 1'b0 || fifo_if.wr_out_fifo_en_o !== 1'b0 || fifo_if.wr_out_fifo_data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid.fifo_outs: got en %b/%b data %h required 0/0 00", fifo_if.rd_in_fifo_en_o, fifo_if.wr_out_fifo_en_o, fifo_if.wr_out_fifo_data_o);
    end
    n_cmp++;
    if (busy !== 1'b0 || ok_cnt !== 16'h0 || err_cnt !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_mid.status_outs: got busy %b counts %0d/%0d required 0 0/0", busy, ok_cnt, err_cnt);
    end
    in_q.delete();
    repeat (3) @(negedge clk);
    out_q.delete();
    rst = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    repeat (10) @(negedge clk);
    n_cmp++; if (out_q.size() !== 0) begin n_bad++; $display("FAIL reset_mid.no_status: got %0d bytes required 0", out_q.size()); end
    test_directed("after_reset", {8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D},
                  {8'h5A, 8'h03, 8'h10, 8'h20, 8'h30, 8'h00}, 1, 0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_zero_len();
    test_bad_csum();
    test_back_to_back_random();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
